// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. One full_adder is time-shared across
// all WIDTH bit positions, LSB first, with the carry held in a register
// between bits. Returns sum, carry-out and signed overflow with a one-cycle
// done pulse.

// Single-bit full adder, the only arithmetic element in the datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    // Handshake: start is a request that is accepted on any rising edge where
    // the controller is not busy (IDLE or DONE). There is no backpressure on
    // the result side: done is a one-cycle valid pulse, and sum/c_out/overflow
    // stay stable afterwards until the next result replaces them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Current FSM state; kept as a plainly named signal so checkers can bind to it.
    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_sr;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    full_adder u_fa (
        .a  (a_q[cnt]),
        .b  (b_q[cnt]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept   = start && (state != RUN);
    assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; DONE accepts start directly for back-to-back use.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sum_sr   <= '0;
            cnt      <= '0;
            carry_q  <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1, so the carry-in is forced high.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | c_in;
            cnt     <= '0;
            sum_sr  <= '0;
        end else if (state == RUN) begin
            sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
            carry_q <= fa_co;
            cnt     <= cnt + CW'(1);
            if (last_bit) begin
                // On the MSB step carry_q is the carry into the MSB, so the
                // overflow term needs no separate capture register.
                sum      <= {fa_s, sum_sr[WIDTH-1:1]};
                c_out    <= fa_co;
                overflow <= carry_q ^ fa_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: reset/idle checks, directed vector table,
// back-to-back and held-start handshakes, mid-operation reset, and random
// operations against an arithmetic reference model.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;

    int total;
    int bad;

    // Expected results packed as {c_out, overflow, sum}.
    logic [W+1:0] exp_q[$];
    logic [W-1:0] hold_sum;
    logic         hold_c;
    logic         hold_ovf;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c_in;
        logic [W-1:0] sum;
        logic         c_out;
        logic         ovf;
    } vec_t;

    vec_t tbl[6];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic ci);
        int ux;
        int uy;
        int sx;
        int sy;
        int ur;
        int sr;
        logic co;
        logic ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            ur = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + int'(ci);
            co = (ur > (2 ** W) - 1);
            sr = sx + sy + int'(ci);
        end
        ov = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
        return {co, ov, ur[W-1:0]};
    endfunction

    // Idle cycles: no activity, outputs hold the last result.
    task automatic idle(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_sum", 32'(sum), 32'(hold_sum));
            chk("idle_cout", 32'(c_out), 32'(hold_c));
            chk("idle_ovf", 32'(overflow), 32'(hold_ovf));
        end
    endtask

    // Driver: issue one start at the current negedge, scramble inputs while
    // busy, wait (bounded) for done. Returns in the done cycle so a caller can
    // start again immediately.
    task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic [W+1:0] expv);
        int  nb;
        bit  seen;
        logic [W+1:0] e;
        exp_q.push_back(expv);
        sub   = s;
        a     = x;
        b     = y;
        c_in  = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb    = 0;
        seen  = 1'b0;
        for (int i = 0; i < W + 4 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) nb++;
                chk("run_sum_hold", 32'(sum), 32'(hold_sum));
                a    = W'($urandom);
                b    = W'($urandom);
                sub  = 1'($urandom);
                c_in = 1'($urandom);
                @(negedge clk);
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(nb), 32'(W));
        chk("busy_at_done", 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            chk("queue_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("sum", 32'(sum), 32'(e[W-1:0]));
            chk("ovf", 32'(overflow), 32'(e[W]));
            chk("cout", 32'(c_out), 32'(e[W+1]));
            hold_sum = e[W-1:0];
            hold_ovf = e[W];
            hold_c   = e[W+1];
        end
    endtask

    // start held high with operands changing every cycle: only operands
    // present at accepted edges (every W+1 cycles) may matter.
    task automatic held_test(input int nops);
        int ph;
        logic [W+1:0] e;
        for (int i = 0; i <= nops * (W + 1); i++) begin
            ph = i % (W + 1);
            chk("held_busy", 32'(busy), 32'(i > 0 && ph != 0));
            chk("held_done", 32'(done), 32'(i > 0 && ph == 0));
            if (i > 0 && ph == 0) begin
                if (exp_q.size() == 0) begin
                    chk("held_queue_nonempty", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("held_sum", 32'(sum), 32'(e[W-1:0]));
                    chk("held_ovf", 32'(overflow), 32'(e[W]));
                    chk("held_cout", 32'(c_out), 32'(e[W+1]));
                    hold_sum = e[W-1:0];
                    hold_ovf = e[W];
                    hold_c   = e[W+1];
                end
            end else begin
                chk("held_sum_hold", 32'(sum), 32'(hold_sum));
            end
            if (i < nops * (W + 1)) begin
                start = 1'b1;
                sub   = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                c_in  = 1'($urandom);
                if (ph == 0) exp_q.push_back(model(sub, a, b, c_in));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        hold_sum = '0;
        hold_c   = 1'b0;
        hold_ovf = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;
        c_in     = 1'b0;

        tbl[0] = '{1'b0, 8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

        // Reset for two cycles, then idle.
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        idle(10);

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].c_in,
                  {tbl[i].c_out, tbl[i].ovf, tbl[i].sum});
            idle(1);
        end

        // Start in the DONE cycle: the second operation follows with no IDLE gap.
        do_op(1'b0, 8'h10, 8'h20, 1'b0, {1'b0, 1'b0, 8'h30});
        do_op(1'b1, 8'h00, 8'h01, 1'b0, {1'b0, 1'b0, 8'hFF});
        idle(2);

        // start held high, operands changing every cycle.
        held_test(4);
        idle(2);

        // Reset after 4 RUN cycles: no done, results cleared.
        sub   = 1'b0;
        a     = 8'h12;
        b     = 8'h34;
        c_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(c_out), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        hold_sum = '0;
        hold_c   = 1'b0;
        hold_ovf = 1'b0;
        idle(W + 2);
        do_op(1'b0, 8'h12, 8'h34, 1'b0, {1'b0, 1'b0, 8'h46});
        idle(1);

        // Random operations against the reference model, random gaps (0 = back-to-back).
        for (int i = 0; i < 30; i++) begin
            logic         rs;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            rs = 1'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op(rs, ra, rb, rc, model(rs, ra, rb, rc));
            idle($urandom_range(0, 2));
        end
        idle(1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
